// File: rtl/ad7324_pkg.sv
// Shared constants, control-word field positions and FSM encoding for the
// AD7324 SPI responder.
package ad7324_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 13;
  localparam int CTRL_W     = 13;

  localparam int WRITE_BIT = 15;
  localparam int REG_HI    = 14;
  localparam int REG_LO    = 13;
  localparam int ADD_HI    = 11;
  localparam int ADD_LO    = 10;
  localparam int SEQ_HI    = 4;
  localparam int SEQ_LO    = 3;

  localparam logic [1:0] REG_CTRL   = 2'b00;
  localparam logic [1:0] SEQ_CONSEC = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } fsm_state_t;

  // Only writes addressed to the control register replace it.
  function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [15:0] rx,
                                                    input logic [CTRL_W-1:0] cur);
    if (rx[WRITE_BIT] && (rx[REG_HI:REG_LO] == REG_CTRL))
      return rx[CTRL_W-1:0];
    return cur;
  endfunction

  function automatic logic [1:0] next_ch_ptr(input logic [CTRL_W-1:0] ctrl,
                                             input logic [1:0] ptr);
    if (ctrl[SEQ_HI:SEQ_LO] == SEQ_CONSEC)
      return ptr + 2'd1;
    return ctrl[ADD_HI:ADD_LO];
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchronizer plus one-flop edge detector for asynchronous SPI
// pins; emits the synchronized level and single-clk rise/fall strobes.
module spi_in_sync #(
  parameter int               WIDTH       = 3,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [WIDTH-1:0]                  prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= RST_VAL;
      prev_reg <= RST_VAL;
    end else begin
      sync_reg[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign level = sync_reg[SYNC_STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/ad7324_spi_responder.sv
// AD7324 emulator: answers SPI frames with the previously converted sample
// and decodes control words written by the master.
module ad7324_spi_responder
  import ad7324_pkg::*;
#(
  parameter int DATA_W      = ad7324_pkg::DATA_W,
  parameter int FRAME_BITS  = ad7324_pkg::FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk_in,
  input  logic                cs_n_in,
  input  logic                din_in,
  input  logic [4*DATA_W-1:0] ch_data,
  output logic                dout,
  output logic                dout_oe,
  output logic [CTRL_W-1:0]   ctrl_reg,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 1);
  localparam int                RES_W    = DATA_W + 2;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic [2:0] sync_level, sync_rise, sync_fall;
  logic       sclk_fall, cs_fall, cs_high, din_s;
  logic       unused_sync;

  // Idle levels: sclk high, cs_n high, so reset release shows no edges.
  spi_in_sync #(
    .WIDTH       (3),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (3'b011)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   ({din_in, cs_n_in, sclk_in}),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  assign sclk_fall   = sync_fall[0];
  assign cs_fall     = sync_fall[1];
  assign cs_high     = sync_level[1];
  assign din_s       = sync_level[2];
  assign unused_sync = ^{sync_level[0], sync_rise, sync_fall[2]};

  logic signed [DATA_W-1:0] ch_arr [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ch
      assign ch_arr[gi] = ch_data[DATA_W*gi +: DATA_W];
    end
  endgenerate

  fsm_state_t            state_reg, state_next;
  logic                  done_first_reg;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [FRAME_BITS-1:0] tx_shift_reg, rx_shift_reg;
  logic [RES_W-1:0]      conv_reg, result_reg;
  logic [1:0]            ch_ptr_reg;
  logic [CTRL_W-1:0]     ctrl_next;
  logic [1:0]            ch_ptr_next;
  logic                  start_frame, shift_bit, abort_frame, finish_frame, exit_done;

  assign ctrl_next   = decode_ctrl(rx_shift_reg, ctrl_reg);
  assign ch_ptr_next = next_ch_ptr(ctrl_next, ch_ptr_reg);

  always_comb begin
    state_next   = state_reg;
    start_frame  = 1'b0;
    shift_bit    = 1'b0;
    abort_frame  = 1'b0;
    finish_frame = 1'b0;
    exit_done    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (cs_fall) begin
          start_frame = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // A final falling edge wins over a simultaneous cs_n release.
        if (sclk_fall && (bit_cnt_reg == LAST_BIT)) begin
          shift_bit  = 1'b1;
          state_next = DONE;
        end else if (cs_high) begin
          abort_frame = 1'b1;
          state_next  = IDLE;
        end else if (sclk_fall) begin
          shift_bit = 1'b1;
        end
      end
      DONE: begin
        finish_frame = done_first_reg;
        if (cs_high || cs_fall) begin
          exit_done  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      done_first_reg <= 1'b0;
      bit_cnt_reg    <= '0;
      tx_shift_reg   <= '0;
      rx_shift_reg   <= '0;
      conv_reg       <= '0;
      result_reg     <= '0;
      ch_ptr_reg     <= '0;
      ctrl_reg       <= '0;
      dout           <= 1'b0;
      dout_oe        <= 1'b0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      done_first_reg <= (state_reg == SHIFT) && (state_next == DONE);
      frame_done     <= finish_frame;
      frame_err      <= abort_frame;
      if (start_frame) begin
        conv_reg     <= {ch_ptr_reg, ch_arr[ch_ptr_reg]};
        tx_shift_reg <= {{(FRAME_BITS-RES_W){1'b0}}, result_reg};
        dout         <= 1'b0;
        dout_oe      <= 1'b1;
        bit_cnt_reg  <= '0;
      end
      if (shift_bit) begin
        rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], din_s};
        tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
        dout         <= tx_shift_reg[FRAME_BITS-2];
        bit_cnt_reg  <= bit_cnt_reg + 1'b1;
      end
      if (abort_frame) begin
        dout    <= 1'b0;
        dout_oe <= 1'b0;
      end
      if (finish_frame) begin
        result_reg <= conv_reg;
        ctrl_reg   <= ctrl_next;
        ch_ptr_reg <= ch_ptr_next;
        dout       <= 1'b0;
      end
      if (exit_done) dout_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad7324_spi_responder.sv
// Scoreboard bench for the AD7324 responder: a frame-level model predicts each
// frame's dout word and control register; a monitor checks them on the pulses.
module tb_ad7324_spi_responder;

  localparam int DW = 13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sclk_in = 1'b1;
  logic            cs_n_in = 1'b1;
  logic            din_in = 1'b0;
  logic [4*DW-1:0] ch_data = '0;
  logic            dout, dout_oe, frame_done, frame_err;
  logic [12:0]     ctrl_reg;

  always #5 clk = ~clk;

  ad7324_spi_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk_in    (sclk_in),
    .cs_n_in    (cs_n_in),
    .din_in     (din_in),
    .ch_data    (ch_data),
    .dout       (dout),
    .dout_oe    (dout_oe),
    .ctrl_reg   (ctrl_reg),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit          is_err;
    logic [15:0] word;
    logic [12:0] ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Frame-level reference model state
  logic [12:0] m_ctrl = '0;
  logic [1:0]  m_ptr = '0;
  logic [14:0] m_result = '0;
  logic [12:0] m_ch [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [15:0] cap_bits = '0;
  int          cap_cnt = 0;

  always @(negedge cs_n_in) cap_cnt = 0;

  always @(negedge sclk_in) begin
    if (!cs_n_in && rst_n) begin
      if (cap_cnt < 16) cap_bits = {cap_bits[14:0], dout};
      else chk("dout_after_frame", 32'(dout), 32'd0);
      cap_cnt++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (frame_done || frame_err)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none at %0t",
                 frame_done, frame_err, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", {30'd0, frame_err, frame_done}, e.is_err ? 32'd2 : 32'd1);
        chk("ctrl_reg", 32'(ctrl_reg), 32'(e.ctrl));
        if (!e.is_err) begin
          chk("dout_word", 32'(cap_bits), 32'(e.word));
          chk("dout_oe_in_frame", 32'(dout_oe), 32'd1);
          $display("frame done: word=%h ctrl=%h", cap_bits, ctrl_reg);
        end else begin
          $display("frame aborted: ctrl=%h", ctrl_reg);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_ch(input logic [12:0] c0, input logic [12:0] c1,
                        input logic [12:0] c2, input logic [12:0] c3);
    ch_data = {c3, c2, c1, c0};
    m_ch[0] = c0; m_ch[1] = c1; m_ch[2] = c2; m_ch[3] = c3;
  endtask

  task automatic reset_model();
    m_ctrl = '0; m_ptr = '0; m_result = '0;
  endtask

  task automatic run_frame(input logic [15:0] w, input int n_falls,
                           input int extra, input int rst_at);
    exp_t        e;
    logic [15:0] exp_word;
    logic [14:0] conv;
    logic [12:0] nctrl;
    logic [1:0]  nptr;
    exp_word = {1'b0, m_result};
    conv     = {m_ptr, m_ch[m_ptr]};
    nctrl    = (w[15] && (w[14:13] == 2'b00)) ? w[12:0] : m_ctrl;
    nptr     = (nctrl[4:3] == 2'b11) ? 2'((int'(m_ptr) + 1) % 4) : nctrl[11:10];

    din_in  = w[15];
    cs_n_in = 1'b0;
    #100;
    for (int i = 0; i < n_falls; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("mid_reset_dout_oe", 32'(dout_oe), 32'd0);
        chk("mid_reset_dout", 32'(dout), 32'd0);
        reset_model();
        cs_n_in = 1'b1;
        #40;
        rst_n = 1'b1;
        #100;
        chk("mid_reset_queue", 32'(exp_q.size()), 32'd0);
        return;
      end
      if (i == 15) begin
        e.is_err = 1'b0; e.word = exp_word; e.ctrl = nctrl;
        exp_q.push_back(e);
        m_result = conv; m_ctrl = nctrl; m_ptr = nptr;
      end
      sclk_in = 1'b0;
      #50;
      sclk_in = 1'b1;
      if (i < 15) din_in = w[14-i];
      #50;
    end
    for (int i = 0; i < extra; i++) begin
      sclk_in = 1'b0;
      din_in  = 1'($urandom);
      #50;
      sclk_in = 1'b1;
      #50;
    end
    if (n_falls < 16) begin
      e.is_err = 1'b1; e.word = '0; e.ctrl = m_ctrl;
      exp_q.push_back(e);
    end
    #50;
    cs_n_in = 1'b1;
    #100;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("dout_oe_idle", 32'(dout_oe), 32'd0);
  endtask

  initial begin
    set_ch(13'h0555, 13'h0555, 13'h0555, 13'h0555);
    #3;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_dout_oe", 32'(dout_oe), 32'd0);
    chk("rst_ctrl", 32'(ctrl_reg), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    #19;
    rst_n = 1'b1;
    #100;

    // Quiet first frame returns zero
    run_frame(16'h0000, 16, 0, -1);

    // Fixed-channel write to ch3, then one frame of pipeline latency
    set_ch(13'h0555, 13'h0555, 13'h0555, 13'h1ABC);
    run_frame(16'h8C00, 16, 0, -1);
    run_frame(16'h0000, 16, 0, -1);
    run_frame(16'h0000, 16, 0, -1);

    // Sequencer mode cycles through the channels with wrap
    set_ch(13'd1, 13'd2, 13'd3, 13'd4);
    run_frame(16'h8018, 16, 0, -1);
    for (int k = 0; k < 6; k++) run_frame(16'h0000, 16, 0, -1);

    // Aborted frame leaves control and pipeline untouched
    run_frame(16'hFFFF, 9, 0, -1);
    run_frame(16'h0000, 16, 0, -1);

    // Negative full-scale sample on fixed ch0, plus extra SCLK edges
    set_ch(13'h1000, 13'd2, 13'd3, 13'd4);
    run_frame(16'h8000, 16, 0, -1);
    run_frame(16'h0000, 16, 20, -1);
    run_frame(16'h0000, 16, 0, -1);

    // Reset during a frame, then the pipeline restarts from zero
    run_frame(16'h0000, 16, 0, 7);
    run_frame(16'h0000, 16, 0, -1);

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      logic [15:0] w;
      int          nf;
      set_ch(13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom));
      if ($urandom_range(0, 1) == 0) w = 16'($urandom);
      else w = {3'b100, 13'($urandom)};
      nf = ($urandom_range(0, 99) < 15) ? int'($urandom_range(1, 15)) : 16;
      run_frame(w, nf, (nf == 16) ? int'($urandom_range(0, 5)) : 0, -1);
    end

    #200;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad7324_spi_responder.md
Name: ad7324_spi_responder

Overview:
Synthesizable SPI slave that emulates the AD7324 4-channel ADC on the GPIO SPI pins. It lets the ADC-read/compensator path be closed-loop tested on the FPGA without the real converter. It answers the existing SPI master's frames: it shifts out 16-bit conversion results {0, ch_id[1:0], data[12:0]} and decodes the 16-bit control words the master writes on DIN. Sample values come from four parallel 13-bit two's-complement buses driven by a plant model or test logic.

Parameters:
DATA_W, 13, conversion result width (sign + 12 bits)
FRAME_BITS, 16, SCLK falling edges per frame
SYNC_STAGES, 2, synchronizer depth on sclk/cs_n/din

Ports:
clk  in  1  system clock; must be >= 8x SCLK frequency
rst_n  in  1  asynchronous active-low reset
sclk_in  in  1  SPI clock from master (asynchronous to clk)
cs_n_in  in  1  SPI chip select, active low
din_in  in  1  master-to-slave data
ch_data  in  4*DATA_W  packed samples; ch_data[DATA_W*k +: DATA_W] is channel k, signed
dout  out  1  slave-to-master data
dout_oe  out  1  1 while a frame is active (tristate enable for the GPIO pad)
ctrl_reg  out  13  last control word written (bits [12:0])
frame_done  out  1  1-clk pulse after a full 16-bit frame
frame_err  out  1  1-clk pulse when cs_n rises before 16 falling edges

Behaviour:
- Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector. Detected-edge latency from the pin is SYNC_STAGES+1 clk.
- Reset values: dout=0, dout_oe=0, ctrl_reg=0, frame_done=0, frame_err=0, ch_ptr=0, result_reg=0 (id 0, data 0), FSM=IDLE. Reset mid-frame aborts the frame immediately; no pulse is produced.
- FSM states:
  - IDLE: waits for cs_n fall. On the fall:
    - conv_reg <= {ch_ptr, ch_data[ch_ptr]} ("conversion start").
    - tx_shift <= {1'b0, result_reg}.
    - dout <= 0 (bit 15); dout_oe <= 1; bit_cnt <= 0.
    - -> SHIFT.
  - SHIFT: on each sclk fall:
    - rx_shift <= {rx_shift[14:0], din}; bit_cnt++.
    - tx_shift shifts left; dout <= next bit.
    - After the 16th fall: -> DONE.
    - cs_n rise while bit_cnt < 16: pulse frame_err, dout_oe <= 0, -> IDLE. result_reg, ctrl_reg and ch_ptr are unchanged.
  - DONE: for one clk:
    - result_reg <= conv_reg; frame_done <= 1; decode rx_shift.
    - dout is held at 0.
    - Further sclk edges are ignored until cs_n rises; then dout_oe <= 0 and -> IDLE.
- Result pipeline: frame N outputs the sample captured at the cs_n fall of frame N-1. The first frame after reset returns 16'h0000.
- Control decode: if rx[15]=1 (WRITE) and rx[14:13]=2'b00, then ctrl_reg <= rx[12:0]. Other addresses and WRITE=0 words are discarded.
- Channel pointer, updated in DONE after decode, using the new ctrl_reg:
  - SEQ = ctrl_reg[4:3] = 2'b11: ch_ptr <= ch_ptr+1 mod 4 (3 wraps to 0).
  - Otherwise: ch_ptr <= ctrl_reg[11:10] (ADD1:ADD0).
  - A write takes effect at the next cs_n fall.
- Simultaneous events:
  - cs_n rise and a 16th sclk fall detected in the same clk: the frame counts as complete (DONE path).
  - cs_n fall while in DONE, before cs_n rise was seen, is impossible by protocol; it is treated as IDLE entry on the next clk.
- Arithmetic: data is passed through unmodified (two's complement, no saturation). ch_id is 2 bits.

Decomposition:
- Shared package ad7324_pkg:
  - FRAME_BITS and DATA_W constants.
  - Control field positions: WRITE=15, REG=14:13, ADD=11:10, SEQ=4:3.
  - REG_CTRL=2'b00 and SEQ_CONSEC=2'b11.
  - fsm_state_t (IDLE, SHIFT, DONE).
- One sub-module, spi_in_sync: synchronizer plus edge detector for the three SPI inputs, outputs rise/fall strobes. It is reusable by other GPIO SPI blocks.

Test Plan:
- Reset, then one frame with DIN=0 and ch_data all 13'h0555 -> dout bits = 16'h0000, frame_done pulses once, ctrl_reg=0.
- Write 16'h8C00 (WRITE, ctrl, ADD=11), ch3=13'h1ABC. Next frame captures ch3; the following frame returns 16'h7ABC (id=3).
- Write SEQ=11 (16'h8018), ch0..3 = 1,2,3,4. Six frames return ids/data cycling 0,1,2,3,0 (wrap verified), each with one frame latency.
- cs_n raised after 9 SCLK falls carrying 16'hFFFF -> frame_err=1, ctrl_reg unchanged, next frame's result equals the earlier result (no pipeline advance).
- Negative sample ch0=13'h1000 (-4096) in fixed ch0 -> dout frame 16'h1000; 20 extra SCLK edges before cs_n rise -> ignored, dout=0.
- rst_n asserted mid-frame at bit 7 -> dout_oe=0 immediately, no frame_done, next frame returns 16'h0000.
